// File: rtl/morse_key_ctrl.sv
// Morse key decoder: times key presses/releases in tick units, assembles up to
// four elements and hands out a letter index with a valid/ready handshake.
module morse_key_ctrl #(
    parameter int unsigned DASH_MIN   = 2,
    parameter int unsigned LETTER_GAP = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_i,
    input  logic       tick_i,
    input  logic       letter_ready_i,
    output logic [4:0] letter_o,
    output logic       letter_valid_o,
    output logic       error_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned BUF_W = 4;
    localparam int unsigned ELC_W = 3;
    localparam int unsigned LET_W = 5;

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(15);
    localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(LETTER_GAP);
    localparam logic [ELC_W-1:0] ELC_FULL   = ELC_W'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               key_meta_q, key_s_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [ELC_W-1:0]   elc_q, elc_d;
    logic               inv_q, inv_d;
    logic [LET_W-1:0]   letter_q, letter_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               ovr_q, ovr_d;
    logic               busy_q, busy_d;
    logic [LET_W:0]     dec_c;

    // Pattern lookup: buffer holds elements oldest-first in the low elc bits,
    // 1 = dash. Result bit LET_W flags a legal code.
    function automatic logic [LET_W:0] decode(input logic [ELC_W-1:0] n,
                                              input logic [BUF_W-1:0] p);
        logic [LET_W:0] r;
        r = '0;
        case ({n, p})
            7'b001_0000: r = {1'b1, 5'd4};   // E
            7'b001_0001: r = {1'b1, 5'd19};  // T
            7'b010_0001: r = {1'b1, 5'd0};   // A
            7'b010_0000: r = {1'b1, 5'd8};   // I
            7'b010_0011: r = {1'b1, 5'd12};  // M
            7'b010_0010: r = {1'b1, 5'd13};  // N
            7'b011_0100: r = {1'b1, 5'd3};   // D
            7'b011_0110: r = {1'b1, 5'd6};   // G
            7'b011_0101: r = {1'b1, 5'd10};  // K
            7'b011_0111: r = {1'b1, 5'd14};  // O
            7'b011_0010: r = {1'b1, 5'd17};  // R
            7'b011_0000: r = {1'b1, 5'd18};  // S
            7'b011_0001: r = {1'b1, 5'd20};  // U
            7'b011_0011: r = {1'b1, 5'd22};  // W
            7'b100_1000: r = {1'b1, 5'd1};   // B
            7'b100_1010: r = {1'b1, 5'd2};   // C
            7'b100_0010: r = {1'b1, 5'd5};   // F
            7'b100_0000: r = {1'b1, 5'd7};   // H
            7'b100_0111: r = {1'b1, 5'd9};   // J
            7'b100_0100: r = {1'b1, 5'd11};  // L
            7'b100_0110: r = {1'b1, 5'd15};  // P
            7'b100_1101: r = {1'b1, 5'd16};  // Q
            7'b100_0001: r = {1'b1, 5'd21};  // V
            7'b100_1001: r = {1'b1, 5'd23};  // X
            7'b100_1011: r = {1'b1, 5'd24};  // Y
            7'b100_1100: r = {1'b1, 5'd25};  // Z
            default:     r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        elc_d    = elc_q;
        inv_d    = inv_q;
        letter_d = letter_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
        dec_c    = decode(elc_q, buf_q);

        if (valid_q && letter_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (key_s_q) begin
                    state_d = MARK;
                    cnt_d   = '0;
                    buf_d   = '0;
                    elc_d   = '0;
                    inv_d   = 1'b0;
                end
            end
            MARK: begin
                // Release classifies the element; a tick on this cycle is ignored.
                if (!key_s_q) begin
                    state_d = SPACE;
                    cnt_d   = '0;
                    if (elc_q == ELC_FULL) begin
                        inv_d = 1'b1;
                    end else begin
                        buf_d = {buf_q[BUF_W-2:0], (cnt_q >= DASH_MIN_C)};
                        elc_d = elc_q + ELC_W'(1);
                    end
                end else if (tick_i && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SPACE: begin
                // Letter end wins over a simultaneous press.
                if (cnt_q >= GAP_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (inv_q || !dec_c[LET_W]) begin
                        err_d = 1'b1;
                    end else if (valid_q) begin
                        ovr_d = 1'b1;
                    end else begin
                        letter_d = dec_c[LET_W-1:0];
                        valid_d  = 1'b1;
                    end
                end else if (key_s_q) begin
                    state_d = MARK;
                    cnt_d   = '0;
                end else if (tick_i && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
            cnt_q      <= '0;
            buf_q      <= '0;
            elc_q      <= '0;
            inv_q      <= 1'b0;
            letter_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_meta_q <= key_i;
            key_s_q    <= key_meta_q;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            elc_q      <= elc_d;
            inv_q      <= inv_d;
            letter_q   <= letter_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign letter_o       = letter_q;
    assign letter_valid_o = valid_q;
    assign error_o        = err_q;
    assign overrun_o      = ovr_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_morse_key_ctrl.sv
// Directed bench for morse_key_ctrl: table of letters plus hand sequences for
// overrun, reset mid-letter and tick-count boundaries.
module tb_morse_key_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       tick;
    logic       ready;
    logic [4:0] letter;
    logic       valid;
    logic       err;
    logic       ovr;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int err_cnt = 0;
    int ovr_cnt = 0;
    int vld_cyc = 0;
    int acc_cnt = 0;
    int last_acc = -1;

    always #5 clk = ~clk;

    morse_key_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .key_i          (key),
        .tick_i         (tick),
        .letter_ready_i (ready),
        .letter_o       (letter),
        .letter_valid_o (valid),
        .error_o        (err),
        .overrun_o      (ovr),
        .busy_o         (busy)
    );

    // Pulse and handshake counters sampled mid-cycle.
    always @(negedge clk) begin
        err_cnt = err_cnt + (err === 1'b1 ? 1 : 0);
        ovr_cnt = ovr_cnt + (ovr === 1'b1 ? 1 : 0);
        vld_cyc = vld_cyc + (valid === 1'b1 ? 1 : 0);
        if (valid === 1'b1 && ready === 1'b1) begin
            acc_cnt  = acc_cnt + 1;
            last_acc = int'(letter);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic unit();
        cyc(4);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic press(input int n);
        key = 1'b1;
        repeat (n) unit();
    endtask

    task automatic release_key(input int n);
        key = 1'b0;
        repeat (n) unit();
    endtask

    // pat is written in code order: element 0 is pat[n-1], 1 = dash.
    task automatic send_letter(input int n, input logic [4:0] pat);
        for (int i = 0; i < n; i++) begin
            press(pat[n-1-i] ? 3 : 1);
            release_key((i == n - 1) ? 3 : 1);
        end
        cyc(3);
    endtask

    typedef struct {
        int         n;
        logic [4:0] pat;
        int         exp_letter;
        bit         exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int e0, a0, v0, o0;

        vecs[0]  = '{2, 5'b00001, 0,  1'b0};  // A
        vecs[1]  = '{1, 5'b00000, 4,  1'b0};  // E
        vecs[2]  = '{1, 5'b00001, 19, 1'b0};  // T
        vecs[3]  = '{4, 5'b01101, 16, 1'b0};  // Q
        vecs[4]  = '{4, 5'b01100, 25, 1'b0};  // Z
        vecs[5]  = '{4, 5'b00011, 0,  1'b1};  // ..--
        vecs[6]  = '{5, 5'b00000, 0,  1'b1};  // five dots
        vecs[7]  = '{4, 5'b00101, 0,  1'b1};  // .-.-
        vecs[8]  = '{4, 5'b01111, 0,  1'b1};  // ----
        vecs[9]  = '{4, 5'b01110, 0,  1'b1};  // ---.
        vecs[10] = '{3, 5'b00101, 10, 1'b0};  // K
        vecs[11] = '{4, 5'b01011, 24, 1'b0};  // Y

        rst   = 1'b1;
        key   = 1'b0;
        tick  = 1'b0;
        ready = 1'b0;
        cyc(3);
        check("rst_letter", int'(letter), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_error", int'(err), 0);
        check("rst_overrun", int'(ovr), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        cyc(2);
        check("idle_busy", int'(busy), 0);

        // Held letter, then a second letter is dropped as overrun.
        send_letter(1, 5'b00000);
        check("hold_valid", int'(valid), 1);
        check("hold_letter", int'(letter), 4);
        o0 = ovr_cnt;
        e0 = err_cnt;
        send_letter(1, 5'b00001);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_letter_kept", int'(letter), 4);
        check("ovr_valid_kept", int'(valid), 1);
        check("ovr_no_error", err_cnt - e0, 0);
        a0 = acc_cnt;
        ready = 1'b1;
        cyc(1);
        check("ovr_cleared", int'(valid), 0);
        check("ovr_accept_cnt", acc_cnt - a0, 1);
        check("ovr_accept_letter", last_acc, 4);
        check("ovr_letter_after", int'(letter), 4);

        for (int i = 0; i < 12; i++) begin
            e0 = err_cnt;
            a0 = acc_cnt;
            v0 = vld_cyc;
            send_letter(vecs[i].n, vecs[i].pat);
            check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err ? 1 : 0);
            check($sformatf("vec%0d_accept", i), acc_cnt - a0, vecs[i].exp_err ? 0 : 1);
            check($sformatf("vec%0d_valid_cycles", i), vld_cyc - v0, vecs[i].exp_err ? 0 : 1);
            if (!vecs[i].exp_err) begin
                check($sformatf("vec%0d_letter", i), last_acc, vecs[i].exp_letter);
            end
            check($sformatf("vec%0d_busy", i), int'(busy), 0);
        end

        // Asynchronous reset in the middle of a third element.
        press(1);
        release_key(1);
        press(3);
        release_key(1);
        key = 1'b1;
        cyc(6);
        check("mid_busy", int'(busy), 1);
        check("mid_letter_pre", int'(letter), 24);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_letter", int'(letter), 0);
        check("async_valid", int'(valid), 0);
        check("async_error", int'(err), 0);
        check("async_overrun", int'(ovr), 0);
        check("async_busy", int'(busy), 0);
        key = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        e0 = err_cnt;
        a0 = acc_cnt;
        send_letter(2, 5'b00001);
        check("post_rst_accept", acc_cnt - a0, 1);
        check("post_rst_letter", last_acc, 0);
        check("post_rst_err", err_cnt - e0, 0);

        // Tick-count boundaries on press and gap length.
        a0 = acc_cnt;
        press(2);
        release_key(3);
        cyc(3);
        check("bnd_dash2_letter", last_acc, 19);
        press(1);
        release_key(3);
        cyc(3);
        check("bnd_dot1_letter", last_acc, 4);
        check("bnd_gap3_count", acc_cnt - a0, 2);
        a0 = acc_cnt;
        press(1);
        release_key(2);
        press(1);
        release_key(3);
        cyc(3);
        check("bnd_gap2_count", acc_cnt - a0, 1);
        check("bnd_gap2_letter", last_acc, 8);
        check("end_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
